// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU opcodes, forward selects and ID/EX register layout
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // Everything the ID/EX pipeline register holds; an all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm32;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_ctrl;
        logic        alu_src_b;
        logic        reg_write;
        logic        mem_to_reg;
    } id_ex_t;

    // Register 0 is hardwired to zero, so it never matches for forwarding or hazards.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand forward select for one source register (FORWARD_EN)
module forward_unit
    import cpu_pkg::*;
(
    input  logic [4:0]  src_addr,
    input  logic [31:0] src_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [1:0]  fwd_sel,
    output logic [31:0] fwd_data
);

`ifdef FORWARD_EN
    // Youngest producer wins: EX/MEM before MEM/WB before the register file value.
    always_comb begin
        fwd_sel  = FWD_REG;
        fwd_data = src_data;
        if (exmem_reg_write && reg_hit(exmem_rd, src_addr)) begin
            fwd_sel  = FWD_MEM;
            fwd_data = exmem_result;
        end else if (memwb_reg_write && reg_hit(memwb_rd, src_addr)) begin
            fwd_sel  = FWD_WB;
            fwd_data = memwb_result;
        end
    end
`else
    // Without forwarding the operand always comes from the stored register data;
    // the hazard logic in the stage stalls instead.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{src_addr, exmem_reg_write, exmem_rd, exmem_result,
                                 memwb_reg_write, memwb_rd, memwb_result};

    always_comb begin
        fwd_sel  = FWD_REG;
        fwd_data = src_data;
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard detection and forwarding (FORWARD_EN)
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm32,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [3:0]  alu_ctrl,
    input  logic        alu_src_b,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        out_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        hazard_stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    id_ex_t      ex_q;
    id_ex_t      dec_d;
    logic [15:0] stall_cnt_q;
    logic        load_use;
    logic        raw_hit;
    logic [31:0] fwd_rt_data;

    // Pack the decode-stage inputs into the register layout.
    always_comb begin
        dec_d            = '0;
        dec_d.valid      = in_valid;
        dec_d.rs_data    = rs_data;
        dec_d.rt_data    = rt_data;
        dec_d.imm32      = imm32;
        dec_d.rs_addr    = rs_addr;
        dec_d.rt_addr    = rt_addr;
        dec_d.rd_addr    = rd_addr;
        dec_d.alu_ctrl   = alu_ctrl;
        dec_d.alu_src_b  = alu_src_b;
        dec_d.reg_write  = reg_write;
        dec_d.mem_to_reg = mem_to_reg;
    end

    // A load in EX cannot supply its data in time for a dependent instruction in decode.
    assign load_use = ex_q.valid && ex_q.mem_to_reg &&
                      (reg_hit(ex_q.rd_addr, rs_addr) || reg_hit(ex_q.rd_addr, rt_addr));

`ifdef FORWARD_EN
    assign raw_hit = 1'b0;
`else
    // With no bypass paths any in-flight producer of a source register must drain first.
    assign raw_hit = (ex_q.valid && ex_q.reg_write &&
                      (reg_hit(ex_q.rd_addr, rs_addr) || reg_hit(ex_q.rd_addr, rt_addr))) ||
                     (exmem_reg_write &&
                      (reg_hit(exmem_rd, rs_addr) || reg_hit(exmem_rd, rt_addr)));
`endif

    assign hazard_stall = in_valid && (load_use || raw_hit);

    // Pipeline register: reset, flush and hazard load a bubble; stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (hazard_stall) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec_d;
        end
    end

    // Saturating count of cycles spent with a hazard asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    forward_unit u_fwd_a (
        .src_addr        (ex_q.rs_addr),
        .src_data        (ex_q.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_sel         (fwd_a),
        .fwd_data        (alu_a)
    );

    forward_unit u_fwd_b (
        .src_addr        (ex_q.rt_addr),
        .src_data        (ex_q.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_sel         (fwd_b),
        .fwd_data        (fwd_rt_data)
    );

    assign alu_b         = ex_q.alu_src_b ? ex_q.imm32 : fwd_rt_data;
    assign alu_op        = ex_q.alu_ctrl;
    assign out_valid     = ex_q.valid;
    assign ex_rd         = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, alu_src_b, reg_write, mem_to_reg, stall, flush;
    logic [31:0] rs_data, rt_data, imm32;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [3:0]  alu_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        out_valid, ex_reg_write, ex_mem_to_reg, hazard_stall;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .hazard_stall(hazard_stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [3:0] op);
        in_valid = 1'b1;
        rs_addr  = rs;
        rt_addr  = rt;
        rd_addr  = rd;
        rs_data  = rsd;
        rt_data  = rtd;
        alu_ctrl = op;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_src_b = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        stall = 1'b0; flush = 1'b0; rs_data = '0; rt_data = '0; imm32 = '0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0; alu_ctrl = '0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

        // Reset state
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_hazard", hazard_stall, 0);

        // Basic capture: ADD 5,3
        drive(5'd1, 5'd2, 5'd3, 32'h5, 32'h3, ALU_ADD);
        reg_write = 1'b1;
        #1;
        chk("cap_hazard_pre", hazard_stall, 0);
        tick();
        chk("cap_alu_a", alu_a, 32'h5);
        chk("cap_alu_b", alu_b, 32'h3);
        chk("cap_alu_op", alu_op, 2);
        chk("cap_out_valid", out_valid, 1);
        chk("cap_ex_rd", ex_rd, 3);
        chk("cap_ex_reg_write", ex_reg_write, 1);
        chk("cap_fwd_a", fwd_a, 0);

        // Immediate operand selection
        drive(5'd4, 5'd5, 5'd6, 32'h7, 32'h55, ALU_SUB);
        imm32 = 32'h100;
        alu_src_b = 1'b1;
        tick();
        chk("imm_alu_b", alu_b, 32'h100);
        chk("imm_alu_a", alu_a, 32'h7);
        chk("imm_alu_op", alu_op, 6);

        // Forwarding on rs=8 with both EX/MEM and MEM/WB writing r8
        drive(5'd8, 5'd10, 5'd12, 32'h11, 32'h22, ALU_ADD);
        alu_src_b = 1'b0;
        tick();
        in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'hDEAD;
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'hBEEF;
        #1;
`ifdef FORWARD_EN
        chk("fwd_mem_alu_a", alu_a, 32'hDEAD);
        chk("fwd_mem_sel", fwd_a, 2);
`else
        chk("nofwd_mem_alu_a", alu_a, 32'h11);
        chk("nofwd_mem_sel", fwd_a, 0);
`endif
        chk("fwd_mem_alu_b", alu_b, 32'h22);
        chk("fwd_mem_sel_b", fwd_b, 0);
        exmem_reg_write = 1'b0;
        #1;
`ifdef FORWARD_EN
        chk("fwd_wb_alu_a", alu_a, 32'hBEEF);
        chk("fwd_wb_sel", fwd_a, 1);
`else
        chk("nofwd_wb_alu_a", alu_a, 32'h11);
        chk("nofwd_wb_sel", fwd_a, 0);
`endif

        // Register 0 is never forwarded and never a hazard source
        memwb_reg_write = 1'b0;
        drive(5'd0, 5'd0, 5'd13, 32'h77, 32'h88, ALU_XOR);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
        #1;
        chk("r0_alu_a", alu_a, 32'h77);
        chk("r0_fwd_a", fwd_a, 0);
        chk("r0_alu_b", alu_b, 32'h88);
        chk("r0_hazard", hazard_stall, 0);
        exmem_reg_write = 1'b0; exmem_rd = 5'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0;

        // Load-use: lw r9 in EX, next instruction reads r9 through rt
        drive(5'd1, 5'd2, 5'd9, 32'h0, 32'h0, ALU_ADD);
        mem_to_reg = 1'b1;
        tick();
        chk("lu_ex_mem_to_reg", ex_mem_to_reg, 1);
        drive(5'd3, 5'd9, 5'd14, 32'h33, 32'h99, ALU_OR);
        mem_to_reg = 1'b0;
        #1;
        chk("lu_hazard", hazard_stall, 1);
        chk("lu_cnt_pre", stall_cnt, 0);
        tick();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_bubble_rw", ex_reg_write, 0);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_hazard_clear", hazard_stall, 0);
        tick();
        chk("lu_cap_valid", out_valid, 1);
        chk("lu_cap_rd", ex_rd, 14);
        chk("lu_cap_op", alu_op, 1);
        chk("lu_cap_alu_b", alu_b, 32'h99);
        chk("lu_cnt_hold", stall_cnt, 1);

        // Non-load RAW dependency: stalls only without forwarding
        rs_addr = 5'd14;
        #1;
`ifdef FORWARD_EN
        chk("raw_ex_hazard", hazard_stall, 0);
`else
        chk("raw_ex_hazard", hazard_stall, 1);
`endif
        rs_addr = 5'd20;
        exmem_reg_write = 1'b1; exmem_rd = 5'd20;
        #1;
`ifdef FORWARD_EN
        chk("raw_mem_hazard", hazard_stall, 0);
`else
        chk("raw_mem_hazard", hazard_stall, 1);
`endif
        exmem_reg_write = 1'b0; exmem_rd = 5'd0;

        // Downstream stall holds the register
        drive(5'd1, 5'd2, 5'd15, 32'hAAAA, 32'h0, ALU_AND);
        stall = 1'b1;
        tick();
        chk("stall_rd", ex_rd, 14);
        chk("stall_valid", out_valid, 1);
        chk("stall_alu_a", alu_a, 32'h33);

        // Flush beats stall
        flush = 1'b1;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_rd", ex_rd, 0);
        chk("flush_rw", ex_reg_write, 0);
        flush = 1'b0;
        stall = 1'b0;

        drive(5'd1, 5'd2, 5'd16, 32'h1234, 32'h0, ALU_SLT);
        tick();
        chk("recap_valid", out_valid, 1);
        chk("recap_rd", ex_rd, 16);
        chk("recap_alu_a", alu_a, 32'h1234);

        // Reset during a stall discards the held instruction
        stall = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_rd", ex_rd, 0);
        chk("rst_stall_alu_a", alu_a, 0);
        chk("rst_stall_op", alu_op, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        stall = 1'b0;
        drive(5'd1, 5'd2, 5'd17, 32'h4321, 32'h0, ALU_SLL);
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_rd", ex_rd, 17);
        chk("post_rst_op", alu_op, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
